multicycle_controller: RTL and testbench

- Multi-cycle MIPS control FSM; successor to the single-cycle decoder.
- Sequences each instruction over FETCH/DECODE/EXECUTE/MEM/WRITEBACK states and issues per-state datapath enables.
- Handles variable-latency instruction/data memory through a ready handshake with a bounded timeout.
- Extends the ISA with bne and addiu.

---
 rtl/multicycle_controller.sv | 248 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle MIPS control FSM with bounded memory wait.
// Optional: define CTRL_ILLEGAL_TRAP_EN to trap unknown encodings in DECODE.
module multicycle_controller #(
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] ext_op,
   output logic [2:0] alu_control,
   output logic [1:0] pc_src,
   output logic       bus_err,
   output logic [3:0] state
);
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_JR     = 4'd10,
      S_HALT   = 4'd11,
      S_TRAP   = 4'd12
   } state_t;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_NOP  = 6'b000000;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

   state_t          st, nst;
   logic [TO_W-1:0] cnt;
   logic            r_type, is_mem, is_imm, is_br, is_jmp;
   logic            is_jr, is_nop, is_ralu, fn_ok;
   logic [2:0]      r_alu;
   logic            waiting, tmo;

   // classify the instruction held in IR
   always_comb begin
      r_type = opcode == OP_R;
      is_mem = opcode == OP_LW || opcode == OP_SW;
      is_imm = opcode == OP_ADDIU || opcode == OP_ORI
            || opcode == OP_LUI;
      is_br  = opcode == OP_BEQ || opcode == OP_BNE;
      is_jmp = opcode == OP_J || opcode == OP_JAL;
      is_jr  = r_type && funct == FN_JR;
      is_nop = r_type && funct == FN_NOP;
      r_alu  = ALU_ADD;
      fn_ok  = 1'b1;
      unique case (funct)
         FN_ADD, FN_ADDU: r_alu = ALU_ADD;
         FN_SUB, FN_SUBU: r_alu = ALU_SUB;
         FN_AND:          r_alu = ALU_AND;
         FN_OR:           r_alu = ALU_OR;
         FN_SLT:          r_alu = ALU_SLT;
         default:         fn_ok = 1'b0;
      endcase
      is_ralu = r_type && fn_ok;
   end

   // memory wait limit reached with the access still outstanding
   always_comb begin
      waiting = st == S_FETCH || st == S_MEMRD || st == S_MEMWR;
      tmo     = waiting && !mem_ready && cnt == TO_LIM;
   end

   // next state and per-state datapath controls
   always_comb begin
      nst         = st;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      i_or_d      = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = 2'b00;
      mem_to_reg  = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      ext_op      = 2'b00;
      alu_control = ALU_ADD;
      pc_src      = 2'b00;
      unique case (st)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) nst = S_DECODE;
            else if (tmo)  nst = S_HALT;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            unique case (1'b1)
               is_mem:  nst = S_MEMADR;
               is_imm:  nst = S_EXEC;
               is_ralu: nst = S_EXEC;
               is_br:   nst = S_BRANCH;
               is_jmp:  nst = S_JUMP;
               is_jr:   nst = S_JR;
               is_nop:  nst = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
               default: nst = S_TRAP;
`else
               default: nst = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            nst = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) nst = S_MEMWB;
            else if (tmo)  nst = S_HALT;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b01;
            nst = S_FETCH;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) nst = S_FETCH;
            else if (tmo)  nst = S_HALT;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (r_type) begin
               alu_src_b   = 2'b00;
               alu_control = r_alu;
            end else if (opcode == OP_ORI) begin
               ext_op      = 2'b01;
               alu_control = ALU_OR;
            end else if (opcode == OP_LUI) begin
               ext_op      = 2'b10;
            end
            nst = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = r_type ? 2'b01 : 2'b00;
            nst = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a   = 1'b1;
            alu_control = ALU_SUB;
            pc_src      = 2'b01;
            pc_write    = (opcode == OP_BNE) ? !zero : zero;
            nst = S_FETCH;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            if (opcode == OP_JAL) begin
               reg_write  = 1'b1;
               reg_dst    = 2'b10;
               mem_to_reg = 2'b10;
            end
            nst = S_FETCH;
         end
         S_JR: begin
            pc_write = 1'b1;
            pc_src   = 2'b11;
            nst = S_FETCH;
         end
         S_HALT: nst = S_HALT;
         S_TRAP: nst = S_TRAP;
         default: nst = S_FETCH;
      endcase
      if (!reset_n) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         reg_write = 1'b0;
      end
   end

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) st <= S_FETCH;
      else          st <= nst;
   end

   // wait counter: counts stalled cycles, cleared on every state change
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                    cnt <= '0;
      else if (nst != st)              cnt <= '0;
      else if (waiting && !mem_ready) cnt <= cnt + TO_W'(1);
   end

   // sticky bus error flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) bus_err <= 1'b0;
      else if (tmo) bus_err <= 1'b1;
   end

   assign state = st;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven check of the multi-cycle controller.
// Rows are one clock each; corner cases are hand-written sequences.
module tb_multicycle_controller;
   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] opcode, funct;
   logic       zero, mem_ready;
   logic       pc_write, ir_write, mem_read, mem_write, i_or_d;
   logic       reg_write, alu_src_a, bus_err;
   logic [1:0] reg_dst, mem_to_reg, alu_src_b, ext_op, pc_src;
   logic [2:0] alu_control;
   logic [3:0] state;
   logic [19:0] ctrl;

   multicycle_controller dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
      .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write),
      .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
      .i_or_d(i_or_d), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .ext_op(ext_op),
      .alu_control(alu_control), .pc_src(pc_src),
      .bus_err(bus_err), .state(state)
   );

   always #5 clk = ~clk;

   assign ctrl = {pc_write, ir_write, mem_read, mem_write, i_or_d,
                  reg_write, reg_dst, mem_to_reg, alu_src_a,
                  alu_src_b, ext_op, alu_control, pc_src};

   localparam logic [19:0] EN   = 20'hF4000;
   localparam logic [19:0] IOD  = 20'h08000;
   localparam logic [19:0] RDST = 20'h03000;
   localparam logic [19:0] M2R  = 20'h00C00;
   localparam logic [19:0] ASA  = 20'h00200;
   localparam logic [19:0] ASB  = 20'h00180;
   localparam logic [19:0] EXT  = 20'h00060;
   localparam logic [19:0] ALU  = 20'h0001C;
   localparam logic [19:0] PSRC = 20'h00003;
   localparam logic [19:0] M_F   = EN | IOD | ASA | ASB | ALU | PSRC;
   localparam logic [19:0] M_ALU = EN | ASA | ASB | EXT | ALU;
   localparam logic [19:0] M_EXR = EN | ASA | ASB | ALU;
   localparam logic [19:0] M_MEM = EN | IOD;
   localparam logic [19:0] M_WB  = EN | RDST | M2R;
   localparam logic [19:0] M_BR  = EN | ASA | ASB | ALU | PSRC;
   localparam logic [19:0] M_J   = EN | PSRC;
   localparam logic [19:0] M_JAL = EN | RDST | M2R | PSRC;

   localparam logic [5:0] R = 6'b000000, J = 6'b000010, JAL = 6'b000011;
   localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101;
   localparam logic [5:0] ADDIU = 6'b001001, ORI = 6'b001101;
   localparam logic [5:0] LUI = 6'b001111, LW = 6'b100011, SW = 6'b101011;
   localparam logic [2:0] A_ADD = 3'b010, A_SUB = 3'b110;
   localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_SLT = 3'b111;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  fn;
      logic        z;
      logic        rdy;
      logic [3:0]  st;
      logic [19:0] ctl;
      logic [19:0] msk;
   } vec_t;

   vec_t tbl[$];
   int n_chk = 0;
   int n_fail = 0;

   function automatic logic [19:0] c(
      input logic pcw, irw, mr, mw, iod, rw,
      input logic [1:0] rd, m2r,
      input logic asa,
      input logic [1:0] asb, ext,
      input logic [2:0] alu,
      input logic [1:0] ps);
      return {pcw, irw, mr, mw, iod, rw, rd, m2r, asa, asb, ext, alu, ps};
   endfunction

   task automatic chk(input string nm, input logic [19:0] act,
                      input logic [19:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input logic [5:0] op, fn, input logic z, rdy,
                      input logic [3:0] st,
                      input logic [19:0] ctl, msk);
      vec_t v;
      v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
      v.st = st; v.ctl = ctl; v.msk = msk;
      tbl.push_back(v);
   endtask

   task automatic fe(input logic [5:0] op, fn);
      add(op, fn, 0, 1, 0, c(1,1,1,0,0,0,0,0,0,2'b01,0,A_ADD,0), M_F);
   endtask

   task automatic de(input logic [5:0] op, fn);
      add(op, fn, 0, 1, 1, c(0,0,0,0,0,0,0,0,0,2'b11,0,A_ADD,0), M_ALU);
   endtask

   task automatic rtype(input logic [5:0] fn, input logic [2:0] alu);
      fe(R, fn);
      de(R, fn);
      add(R, fn, 0, 1, 6, c(0,0,0,0,0,0,0,0,1,2'b00,0,alu,0), M_EXR);
      add(R, fn, 0, 1, 7, c(0,0,0,0,0,1,2'b01,0,0,0,0,A_ADD,0), M_WB);
   endtask

   task automatic itype(input logic [5:0] op, input logic [1:0] ext,
                        input logic [2:0] alu);
      fe(op, 0);
      de(op, 0);
      add(op, 0, 0, 1, 6, c(0,0,0,0,0,0,0,0,1,2'b10,ext,alu,0), M_ALU);
      add(op, 0, 0, 1, 7, c(0,0,0,0,0,1,2'b00,0,0,0,0,A_ADD,0), M_WB);
   endtask

   task automatic memadr(input logic [5:0] op);
      add(op, 0, 0, 1, 2, c(0,0,0,0,0,0,0,0,1,2'b10,0,A_ADD,0), M_ALU);
   endtask

   task automatic branch(input logic [5:0] op, input logic z, pcw);
      fe(op, 0);
      de(op, 0);
      add(op, 0, z, 1, 8, c(pcw,0,0,0,0,0,0,0,1,2'b00,0,A_SUB,2'b01),
          M_BR);
   endtask

   task automatic apply(input int i);
      vec_t v;
      v = tbl[i];
      opcode = v.op; funct = v.fn; zero = v.z; mem_ready = v.rdy;
      #1;
      chk($sformatf("row%0d state", i), {16'd0, state}, {16'd0, v.st});
      chk($sformatf("row%0d ctrl", i), ctrl & v.msk, v.ctl & v.msk);
      @(negedge clk);
   endtask

   task automatic idle(input logic rdy);
      mem_ready = rdy;
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0;
      opcode = 0; funct = 0; zero = 0; mem_ready = 1'b1;

      rtype(6'b100001, A_ADD);
      rtype(6'b100010, A_SUB);
      rtype(6'b101010, A_SLT);
      rtype(6'b100100, A_AND);
      rtype(6'b100101, A_OR);
      itype(ORI, 2'b01, A_OR);
      itype(LUI, 2'b10, A_ADD);
      itype(ADDIU, 2'b00, A_ADD);
      fe(LW, 0);
      de(LW, 0);
      memadr(LW);
      for (int k = 0; k < 3; k++)
         add(LW, 0, 0, 0, 3, c(0,0,1,0,1,0,0,0,0,0,0,A_ADD,0), M_MEM);
      add(LW, 0, 0, 1, 3, c(0,0,1,0,1,0,0,0,0,0,0,A_ADD,0), M_MEM);
      add(LW, 0, 0, 1, 4, c(0,0,0,0,0,1,2'b00,2'b01,0,0,0,A_ADD,0),
          M_WB);
      fe(SW, 0);
      de(SW, 0);
      memadr(SW);
      add(SW, 0, 0, 0, 5, c(0,0,0,1,1,0,0,0,0,0,0,A_ADD,0), M_MEM);
      add(SW, 0, 0, 1, 5, c(0,0,0,1,1,0,0,0,0,0,0,A_ADD,0), M_MEM);
      branch(BEQ, 1, 1);
      branch(BNE, 1, 0);
      branch(BEQ, 0, 0);
      branch(BNE, 0, 1);
      fe(JAL, 0);
      de(JAL, 0);
      add(JAL, 0, 0, 1, 9, c(1,0,0,0,0,1,2'b10,2'b10,0,0,0,A_ADD,2'b10),
          M_JAL);
      fe(J, 0);
      de(J, 0);
      add(J, 0, 0, 1, 9, c(1,0,0,0,0,0,0,0,0,0,0,A_ADD,2'b10), M_J);
      fe(R, 6'b001000);
      de(R, 6'b001000);
      add(R, 6'b001000, 0, 1, 10, c(1,0,0,0,0,0,0,0,0,0,0,A_ADD,2'b11),
          M_J);
      fe(R, 6'b000000);
      de(R, 6'b000000);
      add(R, 6'b100001, 0, 0, 0, c(0,0,1,0,0,0,0,0,0,2'b01,0,A_ADD,0),
          M_F);
      rtype(6'b100001, A_ADD);

      // held in reset: FETCH, enables low, no error
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset state", {16'd0, state}, 20'd0);
      chk("reset enables", ctrl & EN, 20'd0);
      chk("reset bus_err", {19'd0, bus_err}, 20'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) apply(i);
      chk("bus_err after table", {19'd0, bus_err}, 20'd0);

      // ready arriving exactly at the wait limit still wins
      opcode = R; funct = 6'b000000;
      for (int k = 0; k < 15; k++) idle(1'b0);
      mem_ready = 1'b1;
      #1;
      chk("limit fetch state", {16'd0, state}, 20'd0);
      chk("limit ir_write", {19'd0, ir_write}, 20'd1);
      @(negedge clk);
      #1;
      chk("limit decode", {16'd0, state}, 20'd1);
      chk("limit bus_err", {19'd0, bus_err}, 20'd0);
      @(negedge clk);

      // fetch never completes: bus error and HALT
      for (int k = 0; k < 15; k++) idle(1'b0);
      #1;
      chk("tmo pre state", {16'd0, state}, 20'd0);
      chk("tmo pre bus_err", {19'd0, bus_err}, 20'd0);
      @(negedge clk);
      #1;
      chk("tmo halt", {16'd0, state}, 20'd11);
      chk("tmo bus_err", {19'd0, bus_err}, 20'd1);
      mem_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk("halt held", {16'd0, state}, 20'd11);
         chk("halt enables", ctrl & EN, 20'd0);
      end
      reset_n = 1'b0;
      #1;
      chk("halt reset state", {16'd0, state}, 20'd0);
      chk("halt reset bus_err", {19'd0, bus_err}, 20'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // unknown opcode
      opcode = 6'b111111; funct = 6'b000000;
      @(negedge clk);
      #1;
      chk("illegal decode", {16'd0, state}, 20'd1);
      @(negedge clk);
      #1;
`ifdef CTRL_ILLEGAL_TRAP_EN
      chk("illegal trap", {16'd0, state}, 20'd12);
      @(negedge clk);
      #1;
      chk("trap held", {16'd0, state}, 20'd12);
      chk("trap enables", ctrl & EN, 20'd0);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
`else
      chk("illegal to fetch", {16'd0, state}, 20'd0);
`endif

      // reset in the middle of a load
      opcode = LW; funct = 6'b000000;
      @(negedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      #1;
      chk("mid lw memrd", {16'd0, state}, 20'd3);
      reset_n = 1'b0;
      #1;
      chk("mid reset state", {16'd0, state}, 20'd0);
      chk("mid reset enables", ctrl & EN, 20'd0);
      @(negedge clk);
      reset_n = 1'b1;
      mem_ready = 1'b1;
      #1;
      chk("post reset fetch", {16'd0, state}, 20'd0);
      chk("post reset regwr", {19'd0, reg_write}, 20'd0);
      @(negedge clk);
      #1;
      chk("post reset decode", {16'd0, state}, 20'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
